// File: rtl/tpiu_pkg.sv
// Shared definitions for the TPIU frame deframer: sync patterns, the
// sync-state enum and the runtime port-width legality check.
package tpiu_pkg;

    // Full sync in first-received-bit-at-bit-0 order: 31 ones, then a zero.
    localparam logic [31:0] SYNC_FULL = 32'h7FFF_FFFF;
    localparam logic [15:0] SYNC_HALF = 16'h7FFF;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } state_e;

    // Legal runtime widths are 1, 2, 4 and 8, and never wider than the port.
    function automatic logic width_valid(input logic [3:0] width, input int maxwidth);
        logic pow2;
        pow2 = (width == 4'd1) || (width == 4'd2) || (width == 4'd4) || (width == 4'd8);
        return pow2 && (int'(width) <= maxwidth);
    endfunction

endpackage

// File: rtl/tpiu_sync_search.sv
// Combinational full-sync finder. The 31 previously received bits and the
// nbits new bits of this cycle are checked at every offset where the
// pattern could end on a new bit; the earliest such offset is reported.
module tpiu_sync_search
    import tpiu_pkg::*;
#(
    parameter int MAXWIDTH = 4
) (
    input  logic [30:0]           hist,
    input  logic [2*MAXWIDTH-1:0] new_bits,
    input  logic [4:0]            nbits,
    output logic                  match,
    output logic [4:0]            match_idx
);

    localparam int NB = 2 * MAXWIDTH;

    logic [NB+30:0] ext;
    assign ext = {new_bits, hist};

    // Scan from the latest offset down so the earliest matching offset is the one kept.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int k = NB - 1; k >= 0; k--) begin
            if ((5'(k) < nbits) && (ext[k +: 32] == SYNC_FULL)) begin
                match     = 1'b1;
                match_idx = 5'(k);
            end
        end
    end

endmodule

// File: rtl/tpiu_frame_deframer.sv
// TPIU frame deframer: turns registered DDR trace sample pairs into 16-bit
// packet words grouped in FRAME_WORDS-word frames. Realigns on every full
// sync, drops half-syncs and loses sync after 2^TIMEOUT_BITS quiet cycles.
// Optional statistics outputs are built when TPIU_STATS_EN is defined.
module tpiu_frame_deframer
    import tpiu_pkg::*;
#(
    parameter int MAXWIDTH     = 4,
    parameter int FRAME_WORDS  = 8,
    parameter int TIMEOUT_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MAXWIDTH-1:0] traceDina,
    input  logic [MAXWIDTH-1:0] traceDinb,
    input  logic                traceValid,
    input  logic [3:0]          width,
    output logic                WdAvail,
    output logic [15:0]         PacketWd,
    output logic                PacketReset,
    output logic                PacketCommit,
    output logic                sync,
    output logic                cfgErr
`ifdef TPIU_STATS_EN
  , output logic [15:0]         syncCount,
    output logic [15:0]         halfSyncCount,
    output logic [15:0]         frameCount
`endif
);

    localparam int NB = 2 * MAXWIDTH;
    localparam int CW = $clog2(FRAME_WORDS + 1);

    state_e                  state_q, state_d;
    logic [30:0]             hist_q, hist_d;
    logic [4:0]              offset_q, offset_d;
    logic [15:0]             hold_q, hold_d;
    logic                    hold_vld_q, hold_vld_d;
    logic [CW-1:0]           count_q, count_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic [3:0]              width_q, width_d;
    logic                    wd_avail_q, wd_avail_d;
    logic [15:0]             packet_wd_q, packet_wd_d;
    logic                    packet_reset_q, packet_reset_d;
    logic                    packet_commit_q, packet_commit_d;
    logic                    sync_q, sync_d;
    logic                    cfg_err_q, cfg_err_d;

    logic            cfg_bad, width_chg, sync_hit, found, release_held, half_drop;
    logic [4:0]      nbits, found_idx;
    logic [5:0]      sum;
    logic [NB-1:0]   new_bits;
    logic [NB+30:0]  ext;
    logic [15:0]     halfword;

    assign cfg_bad   = !width_valid(width, MAXWIDTH);
    assign width_chg = (width != width_q);
    assign nbits     = {width, 1'b0};
    assign ext       = {new_bits, hist_q};
    assign sum       = {1'b0, offset_q} + {1'b0, nbits};
    // The halfword in progress holds offset_q bits, so it begins 31-offset_q into ext.
    assign halfword  = 16'(ext >> (5'd31 - offset_q));
    assign sync_hit  = traceValid && !cfg_bad && !width_chg && found;

    // Pack this cycle's bits in stream order: rising-edge sample, then falling-edge sample.
    always_comb begin
        new_bits = '0;
        for (int i = 0; i < MAXWIDTH; i++) begin
            if (!cfg_bad && (i < int'(width))) begin
                new_bits[i]               = traceDina[i];
                new_bits[i + int'(width)] = traceDinb[i];
            end
        end
    end

    tpiu_sync_search #(
        .MAXWIDTH (MAXWIDTH)
    ) u_search (
        .hist      (hist_q),
        .new_bits  (new_bits),
        .nbits     (nbits),
        .match     (found),
        .match_idx (found_idx)
    );

    // Next-state: config loss, sync realign, halfword assembly/hold/release, timeout.
    always_comb begin
        // NOTE: every _d starts from a default so no branch leaves it unassigned (no latch).
        state_d         = state_q;
        hist_d          = hist_q;
        offset_d        = offset_q;
        hold_d          = hold_q;
        hold_vld_d      = hold_vld_q;
        count_d         = count_q;
        width_d         = width;
        cfg_err_d       = cfg_bad;
        tmo_d           = (tmo_q != '0) ? tmo_q - 1'b1 : tmo_q;
        wd_avail_d      = 1'b0;
        packet_wd_d     = packet_wd_q;
        packet_reset_d  = 1'b0;
        packet_commit_d = 1'b0;
        release_held    = 1'b0;
        half_drop       = 1'b0;

        if (width_chg || cfg_bad) begin
            // Samples are meaningless under a new or illegal width: start over.
            state_d        = UNSYNC;
            hist_d         = '0;
            offset_d       = '0;
            hold_d         = '0;
            hold_vld_d     = 1'b0;
            count_d        = '0;
            tmo_d          = '0;
            packet_reset_d = width_chg;
        end else if (traceValid) begin
            hist_d = 31'(ext >> nbits);
            if (sync_hit) begin
                // Next halfword starts at the bit after the pattern; a pending 0xFFFF is dropped.
                state_d        = SYNC;
                offset_d       = 5'(nbits - 5'd1 - found_idx);
                hold_d         = '0;
                hold_vld_d     = 1'b0;
                count_d        = '0;
                tmo_d          = '1;
                packet_reset_d = 1'b1;
            end else if (state_q == SYNC) begin
                if (sum >= 6'd16) begin
                    offset_d = 5'(sum - 6'd16);
                    // A 0xFFFF/0x7FFF pair is always also caught by the search above.
                    if (tmo_d != '0) begin
                        release_held = hold_vld_q;
                        if (halfword == SYNC_HALF) begin
                            half_drop  = 1'b1;
                            hold_vld_d = 1'b0;
                        end else begin
                            hold_d     = halfword;
                            hold_vld_d = 1'b1;
                        end
                    end
                end else begin
                    offset_d = sum[4:0];
                end
            end
        end

        if (release_held) begin
            wd_avail_d  = 1'b1;
            packet_wd_d = hold_q;
            if (count_q == CW'(FRAME_WORDS - 1)) begin
                count_d         = '0;
                packet_commit_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        if (tmo_d == '0) begin
            state_d = UNSYNC;
        end
        sync_d = (state_d == SYNC) && (tmo_d != '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= UNSYNC;
            hist_q          <= '0;
            offset_q        <= '0;
            hold_q          <= '0;
            hold_vld_q      <= 1'b0;
            count_q         <= '0;
            tmo_q           <= '0;
            width_q         <= '0;
            wd_avail_q      <= 1'b0;
            packet_wd_q     <= '0;
            packet_reset_q  <= 1'b0;
            packet_commit_q <= 1'b0;
            sync_q          <= 1'b0;
            cfg_err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop takes the value computed from pre-edge state.
            state_q         <= state_d;
            hist_q          <= hist_d;
            offset_q        <= offset_d;
            hold_q          <= hold_d;
            hold_vld_q      <= hold_vld_d;
            count_q         <= count_d;
            tmo_q           <= tmo_d;
            width_q         <= width_d;
            wd_avail_q      <= wd_avail_d;
            packet_wd_q     <= packet_wd_d;
            packet_reset_q  <= packet_reset_d;
            packet_commit_q <= packet_commit_d;
            sync_q          <= sync_d;
            cfg_err_q       <= cfg_err_d;
        end
    end

    assign WdAvail      = wd_avail_q;
    assign PacketWd     = packet_wd_q;
    assign PacketReset  = packet_reset_q;
    assign PacketCommit = packet_commit_q;
    assign sync         = sync_q;
    assign cfgErr       = cfg_err_q;

`ifdef TPIU_STATS_EN
    logic [15:0] sync_cnt_q, sync_cnt_d;
    logic [15:0] half_cnt_q, half_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Saturating event counters.
    always_comb begin
        sync_cnt_d  = sync_cnt_q;
        half_cnt_d  = half_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (sync_hit && (sync_cnt_q != 16'hFFFF))          sync_cnt_d  = sync_cnt_q + 16'd1;
        if (half_drop && (half_cnt_q != 16'hFFFF))         half_cnt_d  = half_cnt_q + 16'd1;
        if (packet_commit_d && (frame_cnt_q != 16'hFFFF))  frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_cnt_q  <= '0;
            half_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            sync_cnt_q  <= sync_cnt_d;
            half_cnt_q  <= half_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign syncCount     = sync_cnt_q;
    assign halfSyncCount = half_cnt_q;
    assign frameCount    = frame_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = half_drop;
`endif

endmodule

// File: tb/tb_tpiu_frame_deframer.sv
// Self-checking bench for tpiu_frame_deframer: table-driven frame scenarios
// plus hand-written sequences for realign, timeout, bad width and reset.
module tb_tpiu_frame_deframer;

    localparam int MW     = 4;
    localparam int FW     = 8;
    localparam int TB_TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [MW-1:0] traceDina;
    logic [MW-1:0] traceDinb;
    logic          traceValid;
    logic [3:0]    width;
    logic          WdAvail;
    logic [15:0]   PacketWd;
    logic          PacketReset;
    logic          PacketCommit;
    logic          sync;
    logic          cfgErr;
`ifdef TPIU_STATS_EN
    logic [15:0]   syncCount;
    logic [15:0]   halfSyncCount;
    logic [15:0]   frameCount;
`endif

    tpiu_frame_deframer #(
        .MAXWIDTH     (MW),
        .FRAME_WORDS  (FW),
        .TIMEOUT_BITS (TB_TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .traceDina    (traceDina),
        .traceDinb    (traceDinb),
        .traceValid   (traceValid),
        .width        (width),
        .WdAvail      (WdAvail),
        .PacketWd     (PacketWd),
        .PacketReset  (PacketReset),
        .PacketCommit (PacketCommit),
        .sync         (sync),
        .cfgErr       (cfgErr)
`ifdef TPIU_STATS_EN
      , .syncCount     (syncCount),
        .halfSyncCount (halfSyncCount),
        .frameCount    (frameCount)
`endif
    );

    always #5 clk = ~clk;

    // Observed traffic, written only by the monitor.
    logic [15:0] got_q[$];
    int          commit_at[$];
    int          n_resets = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (WdAvail)      got_q.push_back(PacketWd);
            if (PacketCommit) commit_at.push_back(got_q.size());
            if (PacketReset)  n_resets++;
        end
    end

    int          n_total = 0;
    int          n_bad   = 0;
    bit          bq[$];
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] wd);
        for (int i = 0; i < 16; i++) bq.push_back(wd[i]);
    endtask

    // Two all-ones halfwords then 7FFF_FFFF: stream FFFF_FFFF, 7FFF_FFFF.
    task automatic push_long_sync();
        push_word(16'hFFFF);
        push_word(16'hFFFF);
        push_word(16'hFFFF);
        push_word(16'h7FFF);
    endtask

    task automatic send_stream(input int w);
        while (bq.size() != 0) begin
            @(negedge clk);
            traceValid = 1'b1;
            traceDina  = '0;
            traceDinb  = '0;
            for (int i = 0; i < w; i++) traceDina[i] = (bq.size() != 0) ? bq.pop_front() : 1'b0;
            for (int i = 0; i < w; i++) traceDinb[i] = (bq.size() != 0) ? bq.pop_front() : 1'b0;
        end
        @(negedge clk);
        traceValid = 1'b0;
        traceDina  = '0;
        traceDinb  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        traceValid = 1'b0;
        traceDina  = '0;
        traceDinb  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_words(input string pfx, input int base_w);
        check({pfx, "_nwords"}, 32'(got_q.size() - base_w), 32'(exp_q.size()));
        for (int i = 0; (i < exp_q.size()) && (base_w + i < got_q.size()); i++)
            check($sformatf("%s_wd%0d", pfx, i), 32'(got_q[base_w + i]), 32'(exp_q[i]));
    endtask

    typedef struct {
        logic [3:0]  w;
        int          pre_bits;
        bit          half_sync;
        logic [15:0] base;
        int          exp_commit_at;
        int          exp_resets;
    } vec_t;

    vec_t vecs[4];
    int   base_w, base_c, base_r;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd4, 0, 1'b0, 16'h1234, 8, 1};
        vecs[1] = '{4'd1, 3, 1'b0, 16'h1234, 8, 1};
        vecs[2] = '{4'd2, 0, 1'b1, 16'h2000, 8, 1};
        vecs[3] = '{4'd4, 5, 1'b1, 16'hA5A0, 8, 1};

        rst        = 1'b0;
        width      = 4'd4;
        traceValid = 1'b0;
        traceDina  = '0;
        traceDinb  = '0;
        #3;
        check("rst_wdavail", 32'(WdAvail), 0);
        check("rst_packetwd", 32'(PacketWd), 0);
        check("rst_packetreset", 32'(PacketReset), 0);
        check("rst_commit", 32'(PacketCommit), 0);
        check("rst_sync", 32'(sync), 0);
        check("rst_cfgerr", 32'(cfgErr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        // Width register leaves reset at 0, so the first clock sees a width change.
        check("init_width_reset", 32'(PacketReset), 1);

        // Table: sync then eight data words (plus a filler that flushes the hold register).
        for (int v = 0; v < 4; v++) begin
            do_reset();
            width = vecs[v].w;
            repeat (3) @(negedge clk);
            base_w = got_q.size();
            base_c = commit_at.size();
            base_r = n_resets;
            bq.delete();
            exp_q.delete();
            repeat (vecs[v].pre_bits) bq.push_back(1'b0);
            push_long_sync();
            for (int i = 0; i < FW; i++) begin
                push_word(vecs[v].base + 16'(i));
                exp_q.push_back(vecs[v].base + 16'(i));
                if (vecs[v].half_sync) push_word(16'h7FFF);
            end
            push_word(16'h0000);
            send_stream(int'(vecs[v].w));
            repeat (3) @(negedge clk);
            check_words($sformatf("v%0d", v), base_w);
            check($sformatf("v%0d_ncommit", v), 32'(commit_at.size() - base_c), 1);
            if (commit_at.size() > base_c)
                check($sformatf("v%0d_commit_at", v), 32'(commit_at[base_c] - base_w), 32'(vecs[v].exp_commit_at));
            check($sformatf("v%0d_resets", v), 32'(n_resets - base_r), 32'(vecs[v].exp_resets));
            check($sformatf("v%0d_sync", v), 32'(sync), 1);
        end

        // Realign mid-frame: 5 words, new sync, then a full fresh frame.
        do_reset();
        width = 4'd4;
        repeat (3) @(negedge clk);
        base_w = got_q.size();
        base_c = commit_at.size();
        base_r = n_resets;
        bq.delete();
        exp_q.delete();
        push_long_sync();
        for (int i = 0; i < 5; i++) begin
            push_word(16'h3000 + 16'(i));
            exp_q.push_back(16'h3000 + 16'(i));
        end
        push_word(16'hFFFF);
        push_word(16'h7FFF);
        for (int i = 0; i < FW; i++) begin
            push_word(16'h3100 + 16'(i));
            exp_q.push_back(16'h3100 + 16'(i));
        end
        push_word(16'h0000);
        send_stream(4);
        repeat (3) @(negedge clk);
        check_words("resync", base_w);
        check("resync_ncommit", 32'(commit_at.size() - base_c), 1);
        if (commit_at.size() > base_c)
            check("resync_commit_at", 32'(commit_at[base_c] - base_w), 13);
        check("resync_resets", 32'(n_resets - base_r), 2);

        // Timeout: one sync, then silence for longer than 2^TB_TMO cycles.
        do_reset();
        width = 4'd4;
        repeat (3) @(negedge clk);
        bq.delete();
        push_long_sync();
        send_stream(4);
        check("tmo_sync_up", 32'(sync), 1);
        repeat (200) @(negedge clk);
        check("tmo_sync_held", 32'(sync), 1);
        repeat (100) @(negedge clk);
        check("tmo_sync_lost", 32'(sync), 0);
        base_w = got_q.size();
        bq.delete();
        for (int i = 0; i < 10; i++) push_word(16'h4000 + 16'(i));
        push_word(16'h0000);
        send_stream(4);
        repeat (3) @(negedge clk);
        check("tmo_no_words", 32'(got_q.size() - base_w), 0);

        // Illegal width mid-frame.
        do_reset();
        width = 4'd4;
        repeat (3) @(negedge clk);
        base_w = got_q.size();
        bq.delete();
        push_long_sync();
        for (int i = 0; i < 3; i++) push_word(16'h5000 + 16'(i));
        send_stream(4);
        repeat (2) @(negedge clk);
        check("w3_pre_sync", 32'(sync), 1);
        base_r = n_resets;
        width = 4'd3;
        @(negedge clk);
        check("w3_cfgerr", 32'(cfgErr), 1);
        check("w3_packetreset", 32'(PacketReset), 1);
        check("w3_sync", 32'(sync), 0);
        repeat (4) @(negedge clk);
        check("w3_single_reset", 32'(n_resets - base_r), 1);
        check("w3_cfgerr_held", 32'(cfgErr), 1);
        check("w3_words", 32'(got_q.size() - base_w), 2);
        width = 4'd8;
        repeat (2) @(negedge clk);
        check("w8_over_max", 32'(cfgErr), 1);
        width = 4'd2;
        repeat (2) @(negedge clk);
        check("w2_cfg_ok", 32'(cfgErr), 0);

        // Asynchronous reset mid-frame.
        do_reset();
        width = 4'd4;
        repeat (3) @(negedge clk);
        bq.delete();
        push_long_sync();
        for (int i = 0; i < 3; i++) push_word(16'h6000 + 16'(i));
        send_stream(4);
        @(negedge clk);
        check("midrst_pre_wd", 32'(PacketWd), 32'h6001);
        check("midrst_pre_sync", 32'(sync), 1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_wdavail", 32'(WdAvail), 0);
        check("midrst_packetwd", 32'(PacketWd), 0);
        check("midrst_packetreset", 32'(PacketReset), 0);
        check("midrst_commit", 32'(PacketCommit), 0);
        check("midrst_sync", 32'(sync), 0);
        check("midrst_cfgerr", 32'(cfgErr), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
